axis_deskew: RTL and testbench

AXIS_DESKEW -- requirements
Module: axis_deskew

---
 rtl/axis_deskew.sv | 147 ++++++++++++++
 tb/tb_axis_deskew.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/axis_deskew.sv
`default_nettype none
// ============================================================================
// Module   : axis_deskew
// Brief    : Realigns a diagonally skewed AXI-Stream beat sequence into whole
//            vectors. Column c of beat k carries element c of vector k-c;
//            per-column delay lines line every element of a vector up with
//            its last column, and an output register delivers one aligned
//            vector per accepted beat once the skew has been filled.
// Revision : 1.0 - initial release
// ============================================================================
module axis_deskew #(
    parameter int W = 8,
    parameter int N = 4
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [N-1:0][W-1:0] s_data,
    input  logic                s_valid,
    input  logic                s_last,
    output logic                s_ready,
    output logic [N-1:0][W-1:0] m_data,
    output logic                m_valid,
    output logic                m_last,
    input  logic                m_ready,
    output logic                err
);

    localparam int             CW      = $clog2(N);
    localparam logic [CW-1:0]  CNT_MAX = CW'(N - 1);

    typedef enum logic [0:0] {
        FILL   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CW-1:0]         r_cnt;
    logic [CW-1:0]         w_cnt_nxt;
    logic                  r_err;
    logic                  w_err_nxt;
    logic                  w_load;
    logic                  w_adv;
    logic [N-1:0][W-1:0]   w_aligned;
    logic [N-1:0][W-1:0]   r_m_data;
    logic                  r_m_valid;
    logic                  r_m_last;

    // The output register is the only buffering, so a beat can enter exactly
    // when that register is empty or being drained this cycle.
    assign s_ready = ~r_m_valid | m_ready;
    assign w_adv   = s_valid & s_ready;

    // Column c waits N-1-c beats for the rest of its vector to arrive.
    for (genvar c = 0; c < N - 1; c++) begin : g_col
        localparam int D = N - 1 - c;
        logic [D-1:0][W-1:0] r_dl;

        // Shift register advancing only on accepted beats.
        always_ff @(posedge clk) begin
            if (!rstn) begin
                r_dl <= '0;
            end else if (w_adv) begin
                r_dl[0] <= s_data[c];
                for (int i = 1; i < D; i++) begin
                    r_dl[i] <= r_dl[i-1];
                end
            end
        end

        assign w_aligned[c] = r_dl[D-1];
    end

    // The last column completes the vector and needs no delay.
    assign w_aligned[N-1] = s_data[N-1];

    // Frame state, fill counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= FILL;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Next frame state: fill the skew, then emit one vector per beat;
    // s_last always restarts the frame, and a frame ending mid-fill is short.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = r_err;
        w_load      = 1'b0;
        if (w_adv) begin
            case (r_state)
                FILL: begin
                    if (s_last) begin
                        w_cnt_nxt = '0;
                        w_err_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                        if (w_cnt_nxt == CNT_MAX) begin
                            w_state_nxt = STREAM;
                        end
                    end
                end
                STREAM: begin
                    w_load = 1'b1;
                    if (s_last) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = FILL;
                    end
                end
                default: begin
                    w_state_nxt = FILL;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Output register: a new load wins over a drain, giving no bubble.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_m_data  <= '0;
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
        end else if (w_load) begin
            r_m_data  <= w_aligned;
            r_m_valid <= 1'b1;
            r_m_last  <= s_last;
        end else if (r_m_valid && m_ready) begin
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
        end
    end

    assign m_data  = r_m_data;
    assign m_valid = r_m_valid;
    assign m_last  = r_m_last;
    assign err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_axis_deskew.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_deskew
// Brief    : Directed and randomised bench for axis_deskew (N=4, W=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_deskew;

    localparam int W = 8;
    localparam int N = 4;

    logic                clk = 1'b0;
    logic                rstn;
    logic [N-1:0][W-1:0] s_data;
    logic                s_valid;
    logic                s_last;
    logic                s_ready;
    logic [N-1:0][W-1:0] m_data;
    logic                m_valid;
    logic                m_last;
    logic                m_ready = 1'b1;
    logic                err;

    int  n_vec  = 0;
    int  n_bad  = 0;
    int  stalls = 0;
    bit  rand_rdy  = 1'b0;
    bit  rdy_force = 1'b1;

    logic [N*W:0]   got_q[$];
    logic [N*W:0]   exp_q[$];
    logic [N*W-1:0] vec_mem [16];
    logic [N*W-1:0] basic [5];

    axis_deskew #(.W(W), .N(N)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_last  (s_last),
        .s_ready (s_ready),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_last  (m_last),
        .m_ready (m_ready),
        .err     (err)
    );

    always #5 clk = ~clk;

    // Downstream ready: forced level or random toggling.
    always @(posedge clk) begin
        #2;
        m_ready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_force;
    end

    // Record every output handshake.
    always @(negedge clk) begin
        if (rstn && m_valid && m_ready) got_q.push_back({m_last, m_data});
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_beat(input logic [N*W-1:0] d, input logic last);
        int t;
        bit acc;
        s_data  = d;
        s_last  = last;
        s_valid = 1'b1;
        t   = 0;
        acc = 1'b0;
        while (!acc && t < 200) begin
            @(negedge clk);
            acc = s_ready;
            @(posedge clk);
            #1;
            if (!acc) stalls++;
            t++;
        end
        if (!acc) chk("send_timeout", 64'd0, 64'd1);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_basic();
        for (int i = 0; i < 5; i++) send_beat(basic[i], i == 4);
        exp_q.push_back({1'b0, 32'h04030201});
        exp_q.push_back({1'b1, 32'h08070605});
    endtask

    // Skew vec_mem[0..L-1] into L+N-1 beats and queue the expected vectors.
    task automatic send_frame(input int L, input bit idle);
        logic [N*W-1:0] beat;
        for (int k = 0; k < L + N - 1; k++) begin
            beat = '0;
            for (int c = 0; c < N; c++) begin
                if (k - c >= 0 && k - c < L) beat[c*W +: W] = vec_mem[k-c][c*W +: W];
            end
            send_beat(beat, k == L + N - 2);
            if (idle && $urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        for (int v = 0; v < L; v++) exp_q.push_back({v == L - 1, vec_mem[v]});
    endtask

    task automatic check_outputs(input string tag);
        int n;
        rand_rdy  = 1'b0;
        rdy_force = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk({tag, "_vec"}, 64'(got_q[i]), 64'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        basic[0] = 32'h00000001;
        basic[1] = 32'h00000205;
        basic[2] = 32'h00030600;
        basic[3] = 32'h04070000;
        basic[4] = 32'h08000000;

        rstn    = 1'b0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_last",  64'(m_last),  64'd0);
        chk("rst_m_data",  64'(m_data),  64'd0);
        chk("rst_err",     64'(err),     64'd0);
        rstn = 1'b1;
        @(negedge clk);
        chk("rst_s_ready", 64'(s_ready), 64'd1);
        @(posedge clk);
        #1;

        // Basic frame with latency checks.
        for (int i = 0; i < 5; i++) begin
            send_beat(basic[i], i == 4);
            if (i == 2) chk("lat_before", 64'(m_valid), 64'd0);
            if (i == 3) begin
                chk("lat_m_valid", 64'(m_valid), 64'd1);
                chk("lat_m_data",  64'(m_data),  64'h04030201);
            end
        end
        exp_q.push_back({1'b0, 32'h04030201});
        exp_q.push_back({1'b1, 32'h08070605});
        check_outputs("basic");
        chk("basic_err", 64'(err), 64'd0);

        // Backpressure: downstream stalled for 3 cycles after first output.
        rdy_force = 1'b0;
        for (int i = 0; i < 4; i++) send_beat(basic[i], 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_m_valid", 64'(m_valid), 64'd1);
            chk("bp_m_data",  64'(m_data),  64'h04030201);
            chk("bp_m_last",  64'(m_last),  64'd0);
            chk("bp_s_ready", 64'(s_ready), 64'd0);
            @(posedge clk);
            #1;
        end
        rdy_force = 1'b1;
        send_beat(basic[4], 1'b1);
        exp_q.push_back({1'b0, 32'h04030201});
        exp_q.push_back({1'b1, 32'h08070605});
        check_outputs("bp");

        // Short frame: three beats only.
        send_beat(basic[0], 1'b0);
        send_beat(basic[1], 1'b0);
        send_beat(basic[2], 1'b1);
        check_outputs("short");
        chk("short_err", 64'(err), 64'd1);
        send_basic();
        check_outputs("after_short");
        chk("short_err_sticky", 64'(err), 64'd1);

        // Back-to-back frames with no idle cycles.
        stalls = 0;
        vec_mem[0] = 32'h04030201;
        vec_mem[1] = 32'h08070605;
        send_frame(2, 1'b0);
        vec_mem[0] = 32'h0c0b0a09;
        vec_mem[1] = 32'h100f0e0d;
        send_frame(2, 1'b0);
        chk("b2b_stalls", 64'(stalls), 64'd0);
        check_outputs("b2b");

        // Reset in the middle of a frame.
        send_beat(basic[0], 1'b0);
        send_beat(basic[1], 1'b0);
        rstn = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        chk("mid_rst_err", 64'(err), 64'd0);
        send_basic();
        check_outputs("mid_rst");

        // Random frames with random gaps and downstream stalls.
        for (int f = 0; f < 8; f++) begin
            int L;
            L = $urandom_range(1, 16);
            for (int v = 0; v < L; v++) vec_mem[v] = $urandom;
            rand_rdy = 1'b1;
            send_frame(L, 1'b1);
        end
        check_outputs("rand");
        chk("rand_err", 64'(err), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
